// File: rtl/program_counter_pkg.sv
// rtl/program_counter_pkg.sv - branch condition encoding and evaluation helper
package program_counter_pkg;

    import register_file_pkg::*;

    typedef enum logic [2:0] {
        COND_ZERO             = 3'd0,
        COND_NOT_ZERO         = 3'd1,
        COND_POSITIVE         = 3'd2,
        COND_NEGATIVE         = 3'd3,
        COND_CARRY_SET        = 3'd4,
        COND_CARRY_CLEARED    = 3'd5,
        COND_OVERFLOW_SET     = 3'd6,
        COND_OVERFLOW_CLEARED = 3'd7
    } branch_condition_e;

    // flags holds the four named status bits at their register_file_pkg positions
    function automatic logic condition_met(input logic [3:0] flags,
                                           input branch_condition_e cond);
        logic met;
        met = 1'b0;
        case (cond)
            COND_ZERO:             met =  flags[ZERO_FLAG];
            COND_NOT_ZERO:         met = !flags[ZERO_FLAG];
            COND_POSITIVE:         met = !flags[NEGATIVE_FLAG];
            COND_NEGATIVE:         met =  flags[NEGATIVE_FLAG];
            COND_CARRY_SET:        met =  flags[CARRY_FLAG];
            COND_CARRY_CLEARED:    met = !flags[CARRY_FLAG];
            COND_OVERFLOW_SET:     met =  flags[OVERFLOW_FLAG];
            COND_OVERFLOW_CLEARED: met = !flags[OVERFLOW_FLAG];
            default:               met = 1'b0;
        endcase
        return met;
    endfunction

endpackage

// File: rtl/register_file_pkg.sv
// rtl/register_file_pkg.sv - shared status register flag bit positions
package register_file_pkg;

    localparam int ZERO_FLAG     = 0;
    localparam int NEGATIVE_FLAG = 1;
    localparam int CARRY_FLAG    = 2;
    localparam int OVERFLOW_FLAG = 3;

endpackage

// File: rtl/branch_condition_unit.sv
// rtl/branch_condition_unit.sv - combinational branch resolution against ALU flags
module branch_condition_unit
    import register_file_pkg::*;
    import program_counter_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] status_register,
    input  branch_condition_e branch_condition,
    input  logic              jump_branch_select,
    input  logic              unconditional_branch,
    output logic              branch_taken
);

    logic [3:0] flags;
    logic       cond_true;
    // Upper status bits carry no branch meaning; folded so they are visibly consumed
    logic       unused_status;

    always_comb begin
        flags                = '0;
        flags[ZERO_FLAG]     = status_register[ZERO_FLAG];
        flags[NEGATIVE_FLAG] = status_register[NEGATIVE_FLAG];
        flags[CARRY_FLAG]    = status_register[CARRY_FLAG];
        flags[OVERFLOW_FLAG] = status_register[OVERFLOW_FLAG];
        cond_true            = condition_met(flags, branch_condition);
        branch_taken         = jump_branch_select & (unconditional_branch | cond_true);
    end

    assign unused_status = ^status_register;

endmodule

// File: rtl/program_counter.sv
// rtl/program_counter.sv - fetch-stage PC with increment/branch; PROGRAM_COUNTER_STALL_EN adds stall
module program_counter
    import program_counter_pkg::*;
#(
    parameter int I_ADDR_W = 12,
    parameter int DATA_W   = 8
) (
    input  logic                clk,
    input  logic                rst,
`ifdef PROGRAM_COUNTER_STALL_EN
    input  logic                stall,
`endif
    input  logic [I_ADDR_W-1:0] imar,
    input  logic [I_ADDR_W-1:0] address_immediate,
    input  logic                jump_branch_select,
    input  logic                immediate_select,
    input  logic                unconditional_branch,
    input  logic [DATA_W-1:0]   status_register,
    input  logic [2:0]          branch_condition,
    output logic [I_ADDR_W-1:0] pc,
    output logic                branch_taken
);

    logic [I_ADDR_W-1:0] pc_q;
    logic [I_ADDR_W-1:0] pc_d;
    logic [I_ADDR_W-1:0] target;

    branch_condition_unit #(
        .DATA_W (DATA_W)
    ) u_branch_condition_unit (
        .status_register      (status_register),
        .branch_condition     (branch_condition_e'(branch_condition)),
        .jump_branch_select   (jump_branch_select),
        .unconditional_branch (unconditional_branch),
        .branch_taken         (branch_taken)
    );

    always_comb begin
        target = immediate_select ? address_immediate : imar;
        pc_d   = branch_taken ? target : pc_q + {{(I_ADDR_W-1){1'b0}}, 1'b1};
`ifdef PROGRAM_COUNTER_STALL_EN
        if (stall) begin
            pc_d = pc_q;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc = pc_q;

endmodule

// File: tb/tb_program_counter.sv
// tb/tb_program_counter.sv - randomized and directed check of program_counter against a reference model
module tb_program_counter;

    localparam int I_ADDR_W = 12;
    localparam int DATA_W   = 8;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                stall = 1'b0;
    logic [I_ADDR_W-1:0] imar = '0;
    logic [I_ADDR_W-1:0] address_immediate = '0;
    logic                jump_branch_select = 1'b0;
    logic                immediate_select = 1'b0;
    logic                unconditional_branch = 1'b0;
    logic [DATA_W-1:0]   status_register = '0;
    logic [2:0]          branch_condition = '0;
    logic [I_ADDR_W-1:0] pc;
    logic                branch_taken;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_pc   = 0;

    // Which flag each condition inspects and the value that makes it true
    int flag_of [8] = '{0, 0, 1, 1, 2, 2, 3, 3};
    int want_of [8] = '{1, 0, 0, 1, 1, 0, 1, 0};

    always #5 clk = ~clk;

    program_counter #(
        .I_ADDR_W (I_ADDR_W),
        .DATA_W   (DATA_W)
    ) dut (
        .clk                  (clk),
        .rst                  (rst),
`ifdef PROGRAM_COUNTER_STALL_EN
        .stall                (stall),
`endif
        .imar                 (imar),
        .address_immediate    (address_immediate),
        .jump_branch_select   (jump_branch_select),
        .immediate_select     (immediate_select),
        .unconditional_branch (unconditional_branch),
        .status_register      (status_register),
        .branch_condition     (branch_condition),
        .pc                   (pc),
        .branch_taken         (branch_taken)
    );

    function automatic bit model_taken(bit jbs, bit unc, int cond, int status);
        bit flag_val;
        if (!jbs) return 1'b0;
        if (unc) return 1'b1;
        flag_val = ((status >> flag_of[cond]) & 1) != 0;
        return flag_val == (want_of[cond] != 0);
    endfunction

    task automatic step(input string tag, input bit r, input bit jbs, input bit isel,
                        input bit unc, input int cond, input int status,
                        input int imm, input int ima, input bit stl);
        bit exp_taken;
        int target;
        bit stall_on;
        @(negedge clk);
        rst                  = r;
        jump_branch_select   = jbs;
        immediate_select     = isel;
        unconditional_branch = unc;
        branch_condition     = 3'(cond);
        status_register      = 8'(status);
        address_immediate    = 12'(imm);
        imar                 = 12'(ima);
        stall                = stl;
        exp_taken = model_taken(jbs, unc, cond, status);
        target    = isel ? (imm % 4096) : (ima % 4096);
`ifdef PROGRAM_COUNTER_STALL_EN
        stall_on = stl;
`else
        stall_on = 1'b0;
`endif
        #1;
        n_checks++;
        assert (branch_taken === exp_taken)
        else begin
            n_fail++;
            $error("FAIL %s branch_taken: observed %b expected %b", tag, branch_taken, exp_taken);
        end
        if (r) exp_pc = 0;
        else if (stall_on) exp_pc = exp_pc;
        else if (exp_taken) exp_pc = target;
        else exp_pc = (exp_pc + 1) % 4096;
        @(posedge clk);
        #1;
        n_checks++;
        assert (pc === 12'(exp_pc))
        else begin
            n_fail++;
            $error("FAIL %s pc: observed %h expected %h", tag, pc, 12'(exp_pc));
        end
    endtask

    task automatic idle(input string tag);
        step(tag, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 1'b0);
    endtask

    task automatic jump_imm(input string tag, input int tgt);
        step(tag, 1'b0, 1'b1, 1'b1, 1'b1, int'($urandom_range(0, 7)), int'($urandom_range(0, 255)),
             tgt, int'($urandom_range(0, 4095)), 1'b0);
    endtask

    initial begin
        int status;
        int bitpos;

        step("reset0", 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 1'b0);
        step("reset1", 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 1'b0);
        for (int i = 0; i < 10; i++) idle("incr");

        step("uncond_imm",  1'b0, 1'b1, 1'b1, 1'b1, 0, 8'h00, 12'h100, 12'h777, 1'b0);
        step("uncond_imar", 1'b0, 1'b1, 1'b0, 1'b1, 0, 8'h00, 12'h777, 12'h200, 1'b0);
        idle("after_imar");

        for (int c = 0; c < 8; c++) begin
            bitpos = flag_of[c];
            status = int'($urandom_range(0, 255)) & ~(1 << bitpos);
            if (want_of[c] != 0) status = status | (1 << bitpos);
            step("cond_match", 1'b0, 1'b1, 1'b1, 1'b0, c, status, 12'h300 + c, 12'h0AA, 1'b0);
            status = status ^ (1 << bitpos);
            step("cond_miss",  1'b0, 1'b1, 1'b1, 1'b0, c, status, 12'h400, 12'h0AA, 1'b0);
        end

        jump_imm("wrap_jump", 12'hFFF);
        idle("wrap_incr");

        jump_imm("pre_reset", 12'h0F0);
        step("reset_wins", 1'b1, 1'b1, 1'b1, 1'b1, 0, 0, 12'h555, 12'h555, 1'b0);

        jump_imm("b2b_0", 12'h123);
        jump_imm("b2b_1", 12'h456);
        jump_imm("b2b_2", 12'h789);

        step("jbs_off", 1'b0, 1'b0, 1'b1, 1'b1, 0, 8'hFF, 12'h321, 12'h654, 1'b0);

`ifdef PROGRAM_COUNTER_STALL_EN
        step("stall_branch", 1'b0, 1'b1, 1'b1, 1'b1, 0, 0, 12'hABC, 12'h0, 1'b1);
        step("stall_incr",   1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 12'h0, 12'h0, 1'b1);
        step("stall_reset",  1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 12'h0, 12'h0, 1'b1);
`endif

        for (int i = 0; i < 300; i++) begin
            step("random",
                 ($urandom_range(0, 31) == 0),
                 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 3) == 0),
                 int'($urandom_range(0, 7)),
                 int'($urandom_range(0, 255)),
                 int'($urandom_range(0, 4095)),
                 int'($urandom_range(0, 4095)),
                 ($urandom_range(0, 4) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
